// File: rtl/ram_sequencer.sv
// Burst initiator for the single-port ram: auto-incrementing write/read bursts with a fixed-latency read return.
// Optional RAM_SEQ_WRAP_ERR_EN: adds err and rejects bursts that would cross the top of memory instead of wrapping.
module ram_sequencer #(
   parameter int DATA_WIDTH = 20,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [ADDR_WIDTH-1:0] req_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  mem_write,
   output logic                  mem_load,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  busy,
   output logic                  done
`ifdef RAM_SEQ_WRAP_ERR_EN
   ,
   output logic                  err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  mem_write_q, mem_write_d;
   logic                  mem_load_q, mem_load_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic [1:0]            pipe_q, pipe_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  done_q, done_d;
   logic                  req_bad;

`ifdef RAM_SEQ_WRAP_ERR_EN
   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH:0]   req_end;

   assign req_end = {1'b0, req_addr} + {1'b0, req_len};
   assign req_bad = req_end > (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
   assign err     = err_q;
`else
   assign req_bad = 1'b0;
`endif

   always_comb begin
      // NOTE: every next-state signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d       = state_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      mem_write_d   = 1'b0;
      mem_load_d    = 1'b0;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      done_d        = 1'b0;
`ifdef RAM_SEQ_WRAP_ERR_EN
      err_d         = 1'b0;
`endif
      // Loads issued two cycles ago are returning; mem_q is valid one cycle after mem_load.
      pipe_d        = {pipe_q[0], mem_load_q};
      rd_data_d     = pipe_q[0] ? mem_q : rd_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  done_d = 1'b1;
`ifdef RAM_SEQ_WRAP_ERR_EN
                  err_d  = 1'b1;
`endif
               end else begin
                  addr_d  = req_addr;
                  cnt_d   = req_len;
                  state_d = req_write ? S_WRITE : S_READ;
               end
            end
         end
         S_WRITE: begin
            if (wr_valid) begin
               mem_write_d   = 1'b1;
               mem_address_d = addr_q;
               mem_data_d    = wr_data;
               addr_d        = addr_q + ADDR_WIDTH'(1);
               cnt_d         = cnt_q - ADDR_WIDTH'(1);
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            mem_load_d    = 1'b1;
            mem_address_d = addr_q;
            addr_d        = addr_q + ADDR_WIDTH'(1);
            cnt_d         = cnt_q - ADDR_WIDTH'(1);
            if (cnt_q == '0) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Last return word is on rd_valid now and nothing is behind it.
            if (pipe_q[1] && !pipe_q[0] && !mem_load_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         cnt_q         <= '0;
         mem_write_q   <= 1'b0;
         mem_load_q    <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         pipe_q        <= '0;
         rd_data_q     <= '0;
         done_q        <= 1'b0;
`ifdef RAM_SEQ_WRAP_ERR_EN
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         mem_write_q   <= mem_write_d;
         mem_load_q    <= mem_load_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         pipe_q        <= pipe_d;
         rd_data_q     <= rd_data_d;
         done_q        <= done_d;
`ifdef RAM_SEQ_WRAP_ERR_EN
         err_q         <= err_d;
`endif
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign wr_ready    = (state_q == S_WRITE);
   assign busy        = (state_q != S_IDLE);
   assign mem_write   = mem_write_q;
   assign mem_load    = mem_load_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign rd_valid    = pipe_q[1];
   assign rd_data     = rd_data_q;
   assign done        = done_q;

endmodule

// File: tb/tb_ram_sequencer.sv
// Scoreboard bench for ram_sequencer: stimulus pushes expected memory traffic, a negedge monitor pops and compares.
module tb_ram_sequencer;
   localparam int DW    = 20;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_write = 1'b0;
   logic [AW-1:0] req_addr = '0, req_len = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          req_ready, wr_ready, rd_valid, mem_write, mem_load, busy, done;
   logic [DW-1:0] rd_data, mem_data, mem_q;
   logic [AW-1:0] mem_address;
`ifdef RAM_SEQ_WRAP_ERR_EN
   logic          err;
`endif

   ram_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .mem_write(mem_write), .mem_load(mem_load), .mem_address(mem_address),
      .mem_data(mem_data), .mem_q(mem_q), .busy(busy), .done(done)
`ifdef RAM_SEQ_WRAP_ERR_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port ram with registered read.
   logic [DW-1:0] ram_arr [DEPTH];
   always @(posedge clk) begin
      if (mem_write) ram_arr[mem_address] <= mem_data;
      if (mem_load)  mem_q <= ram_arr[mem_address];
   end

   // Reference model: expected memory contents and expected traffic.
   typedef enum {K_WRITE, K_READ, K_ERR} kind_e;
   typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
   typedef struct {logic [AW-1:0] addr; int cyc;} ld_t;
   typedef struct {logic [DW-1:0] data; int cyc;} rd_t;
   typedef struct {kind_e kind; int cyc;} dn_t;

   logic [DW-1:0] ref_mem [DEPTH];
   wr_t wr_q[$];
   ld_t ld_q[$];
   rd_t rd_q[$];
   dn_t dn_q[$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   wr_t mw; ld_t ml; rd_t mr; dn_t md;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_write || mem_load) check("write_load_exclusive", 64'(mem_write & mem_load), 0);
         if (mem_write) begin
            if (wr_q.size() == 0) check("mem_write_unexpected", 64'(mem_write), 0);
            else begin
               mw = wr_q.pop_front();
               check("wr_addr", 64'(mem_address), 64'(mw.addr));
               check("wr_data", 64'(mem_data), 64'(mw.data));
            end
         end
         if (mem_load) begin
            if (ld_q.size() == 0) check("mem_load_unexpected", 64'(mem_load), 0);
            else begin
               ml = ld_q.pop_front();
               check("ld_addr", 64'(mem_address), 64'(ml.addr));
               check("ld_cycle", 64'(cyc), 64'(ml.cyc));
            end
         end
         if (rd_valid) begin
            if (rd_q.size() == 0) check("rd_valid_unexpected", 64'(rd_valid), 0);
            else begin
               mr = rd_q.pop_front();
               check("rd_data", 64'(rd_data), 64'(mr.data));
               check("rd_cycle", 64'(cyc), 64'(mr.cyc));
            end
         end
         if (done) begin
            if (dn_q.size() == 0) check("done_unexpected", 64'(done), 0);
            else begin
               md = dn_q.pop_front();
               check("done_busy", 64'(busy), 0);
               check("done_req_ready", 64'(req_ready), 1);
               if (md.kind == K_WRITE) begin
                  check("done_with_last_write", 64'(mem_write), 1);
                  check("writes_left_at_done", 64'(wr_q.size()), 0);
               end else begin
                  check("done_cycle", 64'(cyc), 64'(md.cyc));
               end
`ifdef RAM_SEQ_WRAP_ERR_EN
               check("err_with_done", 64'(err), 64'(md.kind == K_ERR));
`endif
            end
         end
`ifdef RAM_SEQ_WRAP_ERR_EN
         if (err && !done) check("err_without_done", 64'(err), 0);
`endif
      end
   end

   // All stimulus tasks are entered and left at #1 after a rising edge.
   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] len,
                         output bit go_write, output int acc_cyc);
      int n = 0;
      int k;
      bit overflow;
      while (!req_ready && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      check("req_ready_wait", 64'(req_ready), 1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len;
      k = cyc;
      acc_cyc = k;
      overflow = (int'(a) + int'(len)) > DEPTH - 1;
      go_write = 1'b0;
`ifdef RAM_SEQ_WRAP_ERR_EN
      if (overflow) dn_q.push_back('{K_ERR, k + 1});
      else
`endif
      if (!wr) begin
         for (int i = 0; i <= int'(len); i++) begin
            int ai = (int'(a) + i) % DEPTH;
            ld_q.push_back('{AW'(ai), k + 2 + i});
            rd_q.push_back('{ref_mem[ai], k + 4 + i});
         end
         dn_q.push_back('{K_READ, k + 5 + int'(len)});
      end else begin
         dn_q.push_back('{K_WRITE, 0});
         go_write = 1'b1;
      end
      if (overflow && go_write) go_write = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_len   = AW'($urandom);
   endtask

   task automatic write_beats(input logic [AW-1:0] a, input logic [AW-1:0] len,
                              input logic [DW-1:0] base, input bit rnd_data,
                              input int bubble_cycle, input bit rnd_bubble, input bit pulse_req);
      int i = 0;
      int c = 0;
      bit bubble;
      logic [DW-1:0] d;
      while (i <= int'(len) && c < 5000) begin
         bubble = (c == bubble_cycle) || (rnd_bubble && $urandom_range(0, 3) == 0);
         d = rnd_data ? DW'($urandom) : base + DW'(i);
         wr_valid = !bubble;
         wr_data  = d;
         if (pulse_req && i < int'(len)) begin
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = AW'($urandom);
            req_len   = AW'($urandom);
         end else req_valid = 1'b0;
         if (wr_valid && wr_ready) begin
            int ai = (int'(a) + i) % DEPTH;
            wr_q.push_back('{AW'(ai), d});
            ref_mem[ai] = d;
            i++;
         end
         @(posedge clk); #1; c++;
      end
      wr_valid  = 1'b0;
      req_valid = 1'b0;
      check("write_beats_taken", 64'(i), 64'(int'(len) + 1));
   endtask

   task automatic burst(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] len,
                        input bit rnd);
      bit go;
      int k;
      do_req(wr, a, len, go, k);
      if (go) write_beats(a, len, 0, 1'b1, -1, rnd, rnd);
`ifdef RAM_SEQ_WRAP_ERR_EN
      else if (wr) for (int j = 0; j < 3; j++) begin
         check("wr_ready_after_err", 64'(wr_ready), 0);
         @(posedge clk); #1;
      end
`endif
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", 64'(req_ready), 1);
      check("rst_wr_ready", 64'(wr_ready), 0);
      check("rst_rd_valid", 64'(rd_valid), 0);
      check("rst_mem_write", 64'(mem_write), 0);
      check("rst_mem_load", 64'(mem_load), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_rd_data", 64'(rd_data), 0);
      check("rst_mem_address", 64'(mem_address), 0);
      check("rst_mem_data", 64'(mem_data), 0);
`ifdef RAM_SEQ_WRAP_ERR_EN
      check("rst_err", 64'(err), 0);
`endif
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit go;
      int k1, k2, n;
      for (int i = 0; i < DEPTH; i++) begin
         logic [DW-1:0] v;
         v = DW'($urandom);
         ram_arr[i] <= v;
         ref_mem[i] = v;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed write with a bubble in the second WRITE cycle, then read-back.
      do_req(1'b1, 10'd5, 10'd3, go, k1);
      write_beats(10'd5, 10'd3, 20'h00011, 1'b0, 1, 1'b0, 1'b0);
      do_req(1'b0, 10'd5, 10'd3, go, k1);

      // Single-beat read at address 0.
      do_req(1'b0, 10'd0, 10'd0, go, k1);

      // Write crossing the top of memory, then read it back.
      burst(1'b1, 10'd1022, 10'd3, 1'b0);
      burst(1'b0, 10'd1022, 10'd3, 1'b0);

      // Request pulses during a write burst must be ignored.
      do_req(1'b1, 10'd100, 10'd7, go, k1);
      if (go) write_beats(10'd100, 10'd7, 0, 1'b1, -1, 1'b0, 1'b1);

      // Back-to-back reads: second accepted in the done cycle of the first.
      do_req(1'b0, 10'd200, 10'd2, go, k1);
      do_req(1'b0, 10'd300, 10'd1, go, k2);
      check("back_to_back_accept_cycle", 64'(k2), 64'(k1 + 5 + 2));

      // Reset during beat 3 of an 8-beat read.
      do_req(1'b0, 10'd40, 10'd7, go, k1);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      wr_q.delete(); ld_q.delete(); rd_q.delete(); dn_q.delete();
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      do_req(1'b0, 10'd41, 10'd0, go, k1);

      // Randomised bursts, including one full-memory read.
      for (int t = 0; t < 30; t++) begin
         burst(1'($urandom), AW'($urandom),
               ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15)),
               1'b1);
      end
      burst(1'b0, AW'($urandom), 10'd1023, 1'b0);
      for (int t = 0; t < 10; t++) burst(1'($urandom), AW'($urandom), AW'($urandom_range(0, 7)), 1'b1);

      n = 0;
      while ((wr_q.size() + ld_q.size() + rd_q.size() + dn_q.size()) != 0 && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      check("wr_q_drained", 64'(wr_q.size()), 0);
      check("ld_q_drained", 64'(ld_q.size()), 0);
      check("rd_q_drained", 64'(rd_q.size()), 0);
      check("done_q_drained", 64'(dn_q.size()), 0);
      check("idle_at_end", 64'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
